// File: rtl/crc_mem_dut_if.sv
// Companion interface that lets a bench keep a one-cycle-delayed copy of mem1_err_detected.
// The interface has no ports and no logic of its own.
interface intf;
    logic mem1_err_detected_dly;

    modport master (output mem1_err_detected_dly);
    modport slave  (input  mem1_err_detected_dly);
endinterface

// File: rtl/crc_mem_dut.sv
// Two CRC-protected single-word memories (32-bit with CRC-8, 8-bit with CRC-4).
// Each word is checked every cycle; single-bit errors are corrected and scrubbed.
module crc_mem_bank #(
    parameter int              DW   = 32,
    parameter int              CW   = 8,
    parameter logic [CW-1:0]   POLY = 8'h07
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr,
    input  logic [DW-1:0] data_in,
    output logic [DW-1:0] data_out,
    output logic          err_detected,
    output logic          err_corrected
);
    logic [DW-1:0] stored_data;
    logic [CW-1:0] stored_crc;

    logic [CW-1:0] syndrome;
    logic [DW-1:0] flip;
    logic [DW-1:0] corrected_data;
    logic [CW-1:0] scrub_crc;
    logic          nonzero;
    logic          correctable;

    // MSB-first, init 0, no reflection, no final XOR.
    function automatic logic [CW-1:0] crc_calc(input logic [DW-1:0] d);
        logic [CW-1:0] c;
        c = '0;
        for (int i = DW - 1; i >= 0; i--) begin
            if (c[CW-1] ^ d[i]) c = {c[CW-2:0], 1'b0} ^ POLY;
            else                c = {c[CW-2:0], 1'b0};
        end
        return c;
    endfunction

    // The CRC is linear, so a flipped data bit i yields syndrome CRC(1<<i);
    // a flipped check bit yields a one-hot syndrome.
    always_comb begin
        syndrome = crc_calc(stored_data) ^ stored_crc;
        flip     = '0;
        for (int i = 0; i < DW; i++) begin
            if (syndrome == crc_calc(DW'(1) << i)) flip[i] = 1'b1;
        end
        nonzero        = |syndrome;
        correctable    = (|flip) || $onehot(syndrome);
        corrected_data = stored_data ^ flip;
        scrub_crc      = crc_calc(corrected_data);
    end

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            // NOTE: storage is cleared as well, so the reset state has syndrome 0.
            stored_data   <= '0;
            stored_crc    <= '0;
            data_out      <= '0;
            err_detected  <= 1'b0;
            err_corrected <= 1'b0;
        end else begin
            data_out      <= corrected_data;
            err_detected  <= nonzero;
            err_corrected <= nonzero && correctable;
            if (wr) begin
                stored_data <= data_in;
                stored_crc  <= crc_calc(data_in);
            end else if (nonzero && correctable) begin
                stored_data <= corrected_data;
                stored_crc  <= scrub_crc;
            end
        end
    end
endmodule

module crc_mem_dut (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem1_wr,
    input  logic [31:0] mem1_data_in,
    output logic [31:0] mem1_data_out,
    output logic        mem1_err_detected,
    output logic        mem1_err_corrected,
    input  logic        mem2_wr,
    input  logic [7:0]  mem2_data_in,
    output logic [7:0]  mem2_data_out,
    output logic        mem2_err_detected,
    output logic        mem2_err_corrected
);
    crc_mem_bank #(.DW(32), .CW(8), .POLY(8'h07)) mem1_i (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr            (mem1_wr),
        .data_in       (mem1_data_in),
        .data_out      (mem1_data_out),
        .err_detected  (mem1_err_detected),
        .err_corrected (mem1_err_corrected)
    );

    crc_mem_bank #(.DW(8), .CW(4), .POLY(4'h3)) mem2_i (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr            (mem2_wr),
        .data_in       (mem2_data_in),
        .data_out      (mem2_data_out),
        .err_detected  (mem2_err_detected),
        .err_corrected (mem2_err_corrected)
    );
endmodule

// File: tb/tb_crc_mem_dut.sv
// Directed bench for crc_mem_dut: reset, write latency, correction, scrub,
// write-over-scrub, random traffic and asynchronous mid-operation reset.
module tb_crc_mem_dut;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem1_wr;
    logic [31:0] mem1_data_in;
    logic [31:0] mem1_data_out;
    logic        mem1_err_detected;
    logic        mem1_err_corrected;
    logic        mem2_wr;
    logic [7:0]  mem2_data_in;
    logic [7:0]  mem2_data_out;
    logic        mem2_err_detected;
    logic        mem2_err_corrected;

    int checks   = 0;
    int failures = 0;

    intf u_intf ();

    crc_mem_dut dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .mem1_wr            (mem1_wr),
        .mem1_data_in       (mem1_data_in),
        .mem1_data_out      (mem1_data_out),
        .mem1_err_detected  (mem1_err_detected),
        .mem1_err_corrected (mem1_err_corrected),
        .mem2_wr            (mem2_wr),
        .mem2_data_in       (mem2_data_in),
        .mem2_data_out      (mem2_data_out),
        .mem2_err_detected  (mem2_err_detected),
        .mem2_err_corrected (mem2_err_corrected)
    );

    always #5 clk = ~clk;

    always @(posedge clk) u_intf.mem1_err_detected_dly <= mem1_err_detected;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b1;
        mem1_wr = 1'b0; mem1_data_in = '0;
        mem2_wr = 1'b0; mem2_data_in = '0;
        cycles(5);
        checks++;
        if ({mem1_data_out, mem1_err_detected, mem1_err_corrected} !== 34'h0) begin
            failures++;
            $display("FAIL reset_mem1: got out=%h det=%b cor=%b, want all 0",
                     mem1_data_out, mem1_err_detected, mem1_err_corrected);
        end
        checks++;
        if ({mem2_data_out, mem2_err_detected, mem2_err_corrected} !== 10'h0) begin
            failures++;
            $display("FAIL reset_mem2: got out=%h det=%b cor=%b, want all 0",
                     mem2_data_out, mem2_err_detected, mem2_err_corrected);
        end
        checks++;
        if ({dut.mem1_i.stored_data, dut.mem1_i.stored_crc} !== 40'h0) begin
            failures++;
            $display("FAIL reset_storage: got data=%h crc=%h, want 0",
                     dut.mem1_i.stored_data, dut.mem1_i.stored_crc);
        end
        rst_n = 1'b0;
        cycles(3);
        checks++;
        if ({mem1_data_out, mem1_err_detected, mem1_err_corrected,
             mem2_data_out, mem2_err_detected, mem2_err_corrected} !== 44'h0) begin
            failures++;
            $display("FAIL post_reset_idle: got m1=%h/%b%b m2=%h/%b%b, want all 0",
                     mem1_data_out, mem1_err_detected, mem1_err_corrected,
                     mem2_data_out, mem2_err_detected, mem2_err_corrected);
        end
    endtask

    task automatic test_write_mem1;
        mem1_wr = 1'b1; mem1_data_in = 32'h0000_0001;
        @(negedge clk);
        mem1_wr = 1'b0;
        checks++;
        if (dut.mem1_i.stored_crc !== 8'h07) begin
            failures++;
            $display("FAIL write1_crc: got %h, want 07", dut.mem1_i.stored_crc);
        end
        @(negedge clk);
        checks++;
        if ({mem1_data_out, mem1_err_detected, mem1_err_corrected} !== {32'h1, 2'b00}) begin
            failures++;
            $display("FAIL write1_latency: got out=%h det=%b cor=%b, want 00000001/0/0",
                     mem1_data_out, mem1_err_detected, mem1_err_corrected);
        end
    endtask

    task automatic test_single_data_error;
        force dut.mem1_i.stored_data = 32'h0;
        @(negedge clk);
        checks++;
        if ({mem1_data_out, mem1_err_detected, mem1_err_corrected} !== {32'h1, 2'b11}) begin
            failures++;
            $display("FAIL single_correct: got out=%h det=%b cor=%b, want 00000001/1/1",
                     mem1_data_out, mem1_err_detected, mem1_err_corrected);
        end
        release dut.mem1_i.stored_data;
        cycles(3);
        checks++;
        if ({mem1_data_out, mem1_err_detected, mem1_err_corrected} !== {32'h1, 2'b00}) begin
            failures++;
            $display("FAIL single_scrub_flags: got out=%h det=%b cor=%b, want 00000001/0/0",
                     mem1_data_out, mem1_err_detected, mem1_err_corrected);
        end
        checks++;
        if ({dut.mem1_i.stored_data, dut.mem1_i.stored_crc} !== {32'h1, 8'h07}) begin
            failures++;
            $display("FAIL single_scrub_store: got data=%h crc=%h, want 00000001/07",
                     dut.mem1_i.stored_data, dut.mem1_i.stored_crc);
        end
    endtask

    task automatic test_double_error;
        mem1_wr = 1'b1; mem1_data_in = 32'h0;
        @(negedge clk);
        mem1_wr = 1'b0;
        force dut.mem1_i.stored_data = 32'h3;
        @(negedge clk);
        checks++;
        if ({mem1_data_out, mem1_err_detected, mem1_err_corrected} !== {32'h3, 2'b10}) begin
            failures++;
            $display("FAIL double_detect: got out=%h det=%b cor=%b, want 00000003/1/0",
                     mem1_data_out, mem1_err_detected, mem1_err_corrected);
        end
        @(negedge clk);
        checks++;
        if ({mem1_err_detected, mem1_err_corrected, u_intf.mem1_err_detected_dly} !== 3'b101) begin
            failures++;
            $display("FAIL double_level: got det=%b cor=%b dly=%b, want 1/0/1",
                     mem1_err_detected, mem1_err_corrected, u_intf.mem1_err_detected_dly);
        end
        release dut.mem1_i.stored_data;
        mem1_wr = 1'b1; mem1_data_in = 32'h0;
        @(negedge clk);
        mem1_wr = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem1_data_out, mem1_err_detected, mem1_err_corrected} !== 34'h0) begin
            failures++;
            $display("FAIL double_rewrite: got out=%h det=%b cor=%b, want 0/0/0",
                     mem1_data_out, mem1_err_detected, mem1_err_corrected);
        end
    endtask

    task automatic test_mem2_check_bit;
        mem2_wr = 1'b1; mem2_data_in = 8'h01;
        @(negedge clk);
        mem2_wr = 1'b0;
        checks++;
        if (dut.mem2_i.stored_crc !== 4'h3) begin
            failures++;
            $display("FAIL mem2_crc: got %h, want 3", dut.mem2_i.stored_crc);
        end
        force dut.mem2_i.stored_crc = 4'h2;
        @(negedge clk);
        checks++;
        if ({mem2_data_out, mem2_err_detected, mem2_err_corrected} !== {8'h01, 2'b11}) begin
            failures++;
            $display("FAIL mem2_checkbit: got out=%h det=%b cor=%b, want 01/1/1",
                     mem2_data_out, mem2_err_detected, mem2_err_corrected);
        end
        release dut.mem2_i.stored_crc;
        cycles(3);
        checks++;
        if ({dut.mem2_i.stored_crc, mem2_err_detected, mem2_err_corrected} !== {4'h3, 2'b00}) begin
            failures++;
            $display("FAIL mem2_scrub: got crc=%h det=%b cor=%b, want 3/0/0",
                     dut.mem2_i.stored_crc, mem2_err_detected, mem2_err_corrected);
        end
    endtask

    task automatic test_write_wins;
        // mem2 holds 0x01; dropping bit 0 is a correctable data error (syndrome 0x3).
        force dut.mem2_i.stored_data = 8'h00;
        @(negedge clk);
        checks++;
        if ({mem2_err_detected, mem2_err_corrected} !== 2'b11) begin
            failures++;
            $display("FAIL wins_detect: got det=%b cor=%b, want 1/1",
                     mem2_err_detected, mem2_err_corrected);
        end
        release dut.mem2_i.stored_data;
        mem2_wr = 1'b1; mem2_data_in = 8'hA5;
        mem1_wr = 1'b1; mem1_data_in = 32'hCAFE_0001;
        @(negedge clk);
        mem2_wr = 1'b0; mem1_wr = 1'b0;
        checks++;
        if ({dut.mem2_i.stored_data, dut.mem2_i.stored_crc} !== {8'hA5, 4'hB}) begin
            failures++;
            $display("FAIL wins_store: got data=%h crc=%h, want A5/B",
                     dut.mem2_i.stored_data, dut.mem2_i.stored_crc);
        end
        @(negedge clk);
        checks++;
        if ({mem2_data_out, mem2_err_detected, mem2_err_corrected,
             mem1_data_out, mem1_err_detected, mem1_err_corrected}
            !== {8'hA5, 2'b00, 32'hCAFE_0001, 2'b00}) begin
            failures++;
            $display("FAIL wins_out: got m2=%h/%b%b m1=%h/%b%b, want A5/00 CAFE0001/00",
                     mem2_data_out, mem2_err_detected, mem2_err_corrected,
                     mem1_data_out, mem1_err_detected, mem1_err_corrected);
        end
    endtask

    task automatic test_random;
        logic [31:0] st1;
        logic [7:0]  st2;
        logic [31:0] exp1;
        logic [7:0]  exp2;
        int          bad;
        st1 = '0; st2 = '0; bad = 0;
        for (int i = 0; i < 100; i++) begin
            mem1_wr      = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            mem2_wr      = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            mem1_data_in = $urandom;
            mem2_data_in = 8'($urandom);
            @(negedge clk);
            exp1 = st1; exp2 = st2;
            if (mem1_wr) st1 = mem1_data_in;
            if (mem2_wr) st2 = mem2_data_in;
            if (i > 0) begin
                checks++;
                if ({mem1_data_out, mem1_err_detected, mem1_err_corrected} !== {exp1, 2'b00}) begin
                    failures++;
                    if (bad++ < 5)
                        $display("FAIL random_mem1[%0d]: got out=%h det=%b cor=%b, want %h/0/0",
                                 i, mem1_data_out, mem1_err_detected, mem1_err_corrected, exp1);
                end
                checks++;
                if ({mem2_data_out, mem2_err_detected, mem2_err_corrected} !== {exp2, 2'b00}) begin
                    failures++;
                    if (bad++ < 5)
                        $display("FAIL random_mem2[%0d]: got out=%h det=%b cor=%b, want %h/0/0",
                                 i, mem2_data_out, mem2_err_detected, mem2_err_corrected, exp2);
                end
            end
        end
        mem1_wr = 1'b0; mem2_wr = 1'b0;
    endtask

    task automatic test_mid_reset;
        mem1_wr = 1'b1; mem1_data_in = 32'h1234_5678;
        mem2_wr = 1'b1; mem2_data_in = 8'h5A;
        @(negedge clk);
        mem1_wr = 1'b0; mem2_wr = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem1_data_out, mem2_data_out} !== {32'h1234_5678, 8'h5A}) begin
            failures++;
            $display("FAIL midrst_pre: got m1=%h m2=%h, want 12345678/5A",
                     mem1_data_out, mem2_data_out);
        end
        mem1_wr = 1'b1; mem1_data_in = 32'hFFFF_FFFF;
        mem2_wr = 1'b1; mem2_data_in = 8'hFF;
        #2 rst_n = 1'b1;
        #1;
        checks++;
        if ({mem1_data_out, mem2_data_out} !== 40'h0) begin
            failures++;
            $display("FAIL midrst_async: got m1=%h m2=%h, want 0/0",
                     mem1_data_out, mem2_data_out);
        end
        @(negedge clk);
        rst_n = 1'b0;
        mem1_wr = 1'b0; mem2_wr = 1'b0;
        checks++;
        if ({dut.mem1_i.stored_data, dut.mem2_i.stored_data} !== 40'h0) begin
            failures++;
            $display("FAIL midrst_discard: got m1=%h m2=%h, want 0/0",
                     dut.mem1_i.stored_data, dut.mem2_i.stored_data);
        end
        cycles(2);
        checks++;
        if ({mem1_data_out, mem1_err_detected, mem1_err_corrected,
             mem2_data_out, mem2_err_detected, mem2_err_corrected} !== 44'h0) begin
            failures++;
            $display("FAIL midrst_after: got m1=%h/%b%b m2=%h/%b%b, want all 0",
                     mem1_data_out, mem1_err_detected, mem1_err_corrected,
                     mem2_data_out, mem2_err_detected, mem2_err_corrected);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        mem1_wr = 1'b0; mem1_data_in = '0;
        mem2_wr = 1'b0; mem2_data_in = '0;
        @(negedge clk);
        test_reset();
        test_write_mem1();
        test_single_data_error();
        test_double_error();
        test_mem2_check_bit();
        test_write_wins();
        test_random();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/crc_mem_dut.md
CRC_MEM_DUT -- requirements
Module: crc_mem_dut

Interface
REQ-001 The block SHALL have one clock and SHALL use an asynchronous, active-high reset.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  asynchronous reset, active-high despite its name; asserting it clears all state immediately.
REQ-004 mem1_wr  input  1  write strobe for MEM1, sampled at rising clk.
REQ-005 mem1_data_in  input  32  MEM1 write data.
REQ-006 mem1_data_out  output  32  registered, corrected MEM1 read data.
REQ-007 mem1_err_detected  output  1  registered flag: MEM1 stored word had a nonzero syndrome.
REQ-008 mem1_err_corrected  output  1  registered flag: MEM1 error was single-bit and corrected.
REQ-009 mem2_wr, mem2_data_in (8), mem2_data_out (8), mem2_err_detected, mem2_err_corrected SHALL match the MEM1 ports, with an 8-bit data width.
REQ-010 Each memory SHALL live in its own sub-instance, mem1_i and mem2_i, holding registers stored_data and stored_crc, so a bench can force faults hierarchically.
REQ-011 A companion interface intf SHALL be delivered.
  - It has no ports.
  - It declares a single 1-bit variable, mem1_err_detected_dly.
  - Its only purpose is to let a bench register a delayed copy of mem1_err_detected.

Function
REQ-012 MEM1 CRC is CRC-8 with polynomial x^8+x^2+x+1 (0x07):
  - init 0, no reflection, no final XOR;
  - data processed MSB first, bit 31 first.
REQ-013 MEM2 CRC is CRC-4 with polynomial x^4+x+1 (0x3):
  - init 0, no reflection, no final XOR;
  - data processed MSB first.
REQ-014 Check values: CRC-8(0x00000001)=0x07; CRC-8(0)=0x00; CRC-4(0x01)=0x3; CRC-4(0)=0x0.
REQ-015 Write: when memX_wr=1 at a rising clk, stored_data <= memX_data_in and stored_crc <= CRC(memX_data_in).
REQ-016 Every cycle, syndrome = CRC(stored_data) XOR stored_crc.
REQ-017 Syndrome 0:
  - data_out <= stored_data;
  - err_detected <= 0;
  - err_corrected <= 0.
REQ-018 Syndrome equal to CRC(1<<i) for data bit i:
  - data_out <= stored_data with bit i inverted;
  - err_detected <= 1;
  - err_corrected <= 1.
REQ-019 Syndrome with exactly one bit set (check-bit error):
  - data_out <= stored_data;
  - err_detected <= 1;
  - err_corrected <= 1.
REQ-020 Any other nonzero syndrome:
  - data_out <= stored_data, uncorrected;
  - err_detected <= 1;
  - err_corrected <= 0.
REQ-021 Scrub: on a corrected error, the same edge SHALL write the corrected data and its recomputed CRC back to storage, so flags clear one cycle later.
REQ-022 Latency: a write captured at edge k SHALL appear on data_out at edge k+1 with flags 0.
REQ-023 A write in the same cycle as a scrub SHALL win; the new data replaces the scrubbed word.
REQ-024 MEM1 and MEM2 SHALL operate fully independently; simultaneous writes are legal.
REQ-025 Aliasing rules:
  - MEM1 (40 bits, distance 4) SHALL never miscorrect a double-bit error.
  - MEM2 (12 bits, distance 3) may miscorrect double-bit errors; this is accepted.
REQ-026 All flags SHALL be level outputs that stay asserted while the error condition persists.

Reset
REQ-027 While rst_n=1, the following SHALL all be 0, and the storage state is consistent (syndrome 0):
  - stored_data and stored_crc;
  - data_out;
  - err_detected and err_corrected.
REQ-028 A reset asserted mid-operation SHALL immediately clear all state and outputs, discarding any pending write or scrub.

Verification
REQ-029 Reset: assert rst_n for 5 cycles -> all outputs 0; after release, with no writes, outputs stay 0.
REQ-030 Write mem1 0x00000001:
  - one cycle later, mem1_data_out=0x00000001 and both flags are 0;
  - mem1_i.stored_crc=0x07.
REQ-031 After REQ-030, force mem1_i.stored_data to 0x00000000 for one cycle:
  - next cycle, mem1_err_detected=1, mem1_err_corrected=1, mem1_data_out=0x00000001;
  - after the scrub, both flags return to 0.
REQ-032 Store 0x00000000 in MEM1, then force stored_data to 0x00000003:
  - mem1_err_detected=1, mem1_err_corrected=0;
  - mem1_data_out=0x00000003.
REQ-033 Write mem2 0x01 (stored_crc=0x3), then force stored_crc to 0x2:
  - mem2_err_detected=1, mem2_err_corrected=1;
  - mem2_data_out=0x01;
  - stored_crc is restored to 0x3.
REQ-034 Random traffic for 100 cycles with random wr and data on both memories and no fault injection:
  - every data_out equals the last written value one cycle after its write;
  - no flag ever asserts.
